// File: rtl/mlp_pkg.sv
// Shared sizing constants for the MLP neuron datapath.
// Holds the default operand and accumulator widths and the full product width.
// Modules take these as parameter defaults so narrower or wider instances stay possible.
package mlp_pkg;

  localparam int A_WIDTH    = 8;
  localparam int B_WIDTH    = 8;
  localparam int R_WIDTH    = 32;
  localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

endpackage

// File: rtl/mac_mult.sv
// Purely combinational signed multiplier: prod = a * b, full precision.
// Ports: a [A_WIDTH] signed, b [B_WIDTH] signed -> prod [PROD_WIDTH] signed.
// No state and no clock. The product always fits in PROD_WIDTH bits, including -2^(A-1) * -2^(B-1).
module mac_mult #(
  parameter int A_WIDTH    = mlp_pkg::A_WIDTH,
  parameter int B_WIDTH    = mlp_pkg::B_WIDTH,
  parameter int PROD_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic signed [A_WIDTH-1:0]    a,
  input  logic signed [B_WIDTH-1:0]    b,
  output logic signed [PROD_WIDTH-1:0] prod
);

  // Widen both operands (sign-extending) before multiplying.
  // This keeps the operation fully signed at the product width.
  assign prod = PROD_WIDTH'(a) * PROD_WIDTH'(b);

endmodule

// File: rtl/mac_unit.sv
// Signed multiply-accumulate core of the MLP neuron datapath.
// Ports: clk, rst (sync, active-high), start (new sum = a*b), valid (sum += a*b),
//        a/b signed operands, result signed accumulator straight from a register.
// Latency is 1 cycle. Priority is rst > start > valid > hold. Accumulation wraps modulo 2^R_WIDTH.
module mac_unit #(
  parameter int A_WIDTH = mlp_pkg::A_WIDTH,
  parameter int B_WIDTH = mlp_pkg::B_WIDTH,
  parameter int R_WIDTH = mlp_pkg::R_WIDTH  // must be >= A_WIDTH + B_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      valid,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic signed [R_WIDTH-1:0] result
);

  localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [R_WIDTH-1:0]    prod_ext;

  mac_mult #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_mult (
    .a    (a),
    .b    (b),
    .prod (prod)
  );

  // A size cast of a signed value sign-extends the product to the accumulator width.
  assign prod_ext = R_WIDTH'(prod);

  // The add is deliberately left to wrap at R_WIDTH.
  // There is no saturation and no overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (start) begin
      result <= prod_ext;
    end else if (valid) begin
      result <= result + prod_ext;
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
module tb_mac_unit;

  logic              clk;
  logic              rst;
  logic              start;
  logic              valid;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic signed [31:0] result;
  logic signed [15:0] result16;

  int tests;
  int fails;

  // Reference state: the running sum as an unbounded integer.
  // It is truncated to each instance's width only when compared.
  longint ref_sum;

  typedef struct {
    logic rst;
    logic start;
    logic valid;
    int   a;
    int   b;
    int   exp;
  } vec_t;

  vec_t vecs[$];

  mac_unit #(.A_WIDTH(8), .B_WIDTH(8), .R_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .result (result)
  );

  mac_unit #(.A_WIDTH(8), .B_WIDTH(8), .R_WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .result (result16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic s, logic v, int av, int bv, int e);
    vec_t t;
    t.rst   = r;
    t.start = s;
    t.valid = v;
    t.a     = av;
    t.b     = bv;
    t.exp   = e;
    return t;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Apply inputs, clock one rising edge, then return 1 time unit after it.
  // Returning after the edge lets callers sample outputs away from the edge.
  task automatic step(input logic r, input logic s, input logic v, input int av, input int bv);
    rst   = r;
    start = s;
    valid = v;
    a     = 8'(av);
    b     = 8'(bv);
    @(posedge clk);
    #1;
  endtask

  // The reference rule is applied with plain integer arithmetic.
  function automatic longint ref_next(longint cur, logic r, logic s, logic v, int av, int bv);
    longint p;
    p = longint'(av) * longint'(bv);
    if (r)      return 0;
    else if (s) return p;
    else if (v) return cur + p;
    else        return cur;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; start = 1'b0; valid = 1'b0; a = '0; b = '0;

    // reset (start/valid high must be overridden)
    vecs.push_back(mk(1, 1, 1,    5,    5,      0));
    vecs.push_back(mk(1, 1, 1,    5,    5,      0));
    // dot product
    vecs.push_back(mk(0, 1, 0,    3,    2,      6));
    vecs.push_back(mk(0, 0, 1,    3,    2,     12));
    vecs.push_back(mk(0, 0, 1,   -1,    5,      7));
    vecs.push_back(mk(0, 0, 1,    4,   -2,     -1));
    vecs.push_back(mk(0, 0, 1,    1,   10,      9));
    // hold with changing operands
    vecs.push_back(mk(0, 0, 0,    7,    7,      9));
    vecs.push_back(mk(0, 0, 0,  -50,   33,      9));
    vecs.push_back(mk(0, 0, 0,  127,  127,      9));
    // restart: start beats valid
    vecs.push_back(mk(0, 1, 1,   -4,   -4,     16));
    // extremes
    vecs.push_back(mk(0, 1, 0, -128, -128,  16384));
    vecs.push_back(mk(0, 1, 0, -128,  127, -16256));
    vecs.push_back(mk(0, 1, 0,  127,  127,  16129));
    // sync reset mid-sum, then accumulate from zero
    vecs.push_back(mk(0, 1, 0,    2,    3,      6));
    vecs.push_back(mk(0, 0, 1,    2,    3,     12));
    vecs.push_back(mk(1, 0, 1,    2,    3,      0));
    vecs.push_back(mk(0, 0, 1,    2,    3,      6));
    vecs.push_back(mk(0, 0, 1,   -3,    3,     -3));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d r32", i), longint'(result), longint'(vecs[i].exp));
      // All table values fit in 16 bits, so the narrow instance must agree.
      check($sformatf("vec%0d r16", i), longint'(result16), longint'(vecs[i].exp));
    end

    // Wrap on the 16-bit instance: 16129, 32258, 48387 - 65536 = -17149.
    step(0, 1, 0, 127, 127);
    check("wrap0 r16", longint'(result16), 16129);
    step(0, 0, 1, 127, 127);
    check("wrap1 r16", longint'(result16), 32258);
    check("wrap1 r32", longint'(result), 32258);
    step(0, 0, 1, 127, 127);
    check("wrap2 r16", longint'(result16), -17149);
    check("wrap2 r32", longint'(result), 48387);
    step(0, 0, 0, 1, 1);
    check("wrap hold r16", longint'(result16), -17149);

    // Randomized run against the integer reference, starting from a reset.
    ref_sum = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, s, v;
      int av, bv;
      longint e16;
      r  = (n == 0) || ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 9) < 6);
      av = int'($urandom_range(0, 255)) - 128;
      bv = int'($urandom_range(0, 255)) - 128;
      ref_sum = ref_next(ref_sum, r, s, v, av, bv);
      step(r, s, v, av, bv);
      check($sformatf("rnd%0d r32", n), longint'(result), longint'(int'(ref_sum)));
      e16 = ref_sum % 65536;
      if (e16 < 0) e16 += 65536;
      if (e16 >= 32768) e16 -= 65536;
      check($sformatf("rnd%0d r16", n), longint'(result16), e16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
